// File: rtl/imm_pkg.sv
// ----------------------------------------------------------------------------
// imm_pkg
//
// Shared constants for the decode-stage immediate generator.
//   - SEXT_* : immediate-type codes carried on the 4-bit 'op' field.
//              Codes 8..15 are undefined and get flagged as illegal.
//   - OP_W        : width of the op field.
//   - FIFO_DEPTH  : number of entries in the output skid buffer.
//   - PTR_W/CNT_W : pointer and occupancy widths for that buffer.
// ----------------------------------------------------------------------------
package imm_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] SEXT_R    = 4'd0;
    localparam logic [OP_W-1:0] SEXT_I    = 4'd1;
    localparam logic [OP_W-1:0] SEXT_MOVE = 4'd2;
    localparam logic [OP_W-1:0] SEXT_S    = 4'd3;
    localparam logic [OP_W-1:0] SEXT_B    = 4'd4;
    localparam logic [OP_W-1:0] SEXT_U    = 4'd5;
    localparam logic [OP_W-1:0] SEXT_J    = 4'd6;
    localparam logic [OP_W-1:0] SEXT_Z    = 4'd7;

    localparam int FIFO_DEPTH = 2;
    // Pointers wrap modulo the depth, so a depth of 2 needs a single bit.
    localparam int PTR_W      = 1;
    // Occupancy has to represent 0..FIFO_DEPTH inclusive.
    localparam int CNT_W      = 2;

endpackage

// File: rtl/imm_extract.sv
// ----------------------------------------------------------------------------
// imm_extract
//
// Purely combinational immediate extraction and extension.
//
// Parameters:
//   XLEN : datapath width, 32 or 64.
//   SHW  : shift-amount width, $clog2(XLEN); derived from XLEN.
//
// Ports:
//   din     in  32    instruction word
//   op      in  OP_W  immediate type code (SEXT_* in imm_pkg)
//   ext     out XLEN  extended immediate (0 for undefined codes)
//   illegal out 1     op is not one of the defined codes
// ----------------------------------------------------------------------------
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic [31:0]     din,
    input  logic [OP_W-1:0] op,
    output logic [XLEN-1:0] ext,
    output logic            illegal
);

    // Replicated sign bit; every signed format takes its upper bits from here.
    logic [XLEN-1:0] sx;

    // The major opcode bits never contribute to any immediate.
    logic unused_opcode;

    assign sx            = {XLEN{din[31]}};
    assign unused_opcode = ^din[6:0];

    always_comb begin
        ext     = '0;
        illegal = 1'b0;
        case (op)
            SEXT_R: begin
                ext = '0;
            end
            SEXT_I: begin
                ext = {sx[XLEN-1:12], din[31:20]};
            end
            SEXT_MOVE: begin
                // Shift amount: 5 bits on RV32, 6 on RV64, never sign-extended.
                ext           = '0;
                ext[SHW-1:0]  = din[20+SHW-1:20];
            end
            SEXT_S: begin
                ext = {sx[XLEN-1:12], din[31:25], din[11:7]};
            end
            SEXT_B: begin
                ext = {sx[XLEN-1:12], din[7], din[30:25], din[11:8], 1'b0};
            end
            SEXT_U: begin
                // Upper bits default to the sign, then the low word is overlaid,
                // which handles both XLEN=32 (no extension) and XLEN=64.
                ext        = sx;
                ext[31:0]  = {din[31:12], 12'b0};
            end
            SEXT_J: begin
                ext = {sx[XLEN-1:20], din[19:12], din[20], din[30:21], 1'b0};
            end
            SEXT_Z: begin
                // CSR immediate: the rs1 field, zero-extended.
                ext       = '0;
                ext[4:0]  = din[19:15];
            end
            default: begin
                ext     = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// imm_gen_pipe
//
// Decode-stage immediate generator with a 2-entry output skid buffer.
// Each accepted {din, op} is extended by imm_extract and queued as an
// {ext, illegal} entry; the head entry is presented downstream with
// valid/ready flow control. 'flush' empties the buffer.
//
// Parameters:
//   XLEN : datapath width, 32 or 64.
//   SHW  : shift-amount width, derived from XLEN.
//
// Ports:
//   cpu_clk     in  1     clock, rising edge
//   cpu_rstn    in  1     asynchronous active-low reset
//   flush       in  1     synchronous flush, beats push and pop
//   in_valid    in  1     upstream offers an instruction
//   in_ready    out 1     buffer has space (registered count only)
//   din         in  32    instruction word
//   op          in  4     immediate type code
//   out_valid   out 1     head entry is valid
//   out_ready   in  1     downstream consumes the head this cycle
//   ext         out XLEN  extended immediate of the head entry
//   out_illegal out 1     head entry came from an undefined op code
// ----------------------------------------------------------------------------
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            cpu_clk,
    input  logic            cpu_rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     din,
    input  logic [OP_W-1:0] op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ext,
    output logic            out_illegal
);

    logic [XLEN-1:0]  new_ext;
    logic             new_illegal;

    logic [XLEN-1:0]  mem_ext [FIFO_DEPTH];
    logic             mem_ill [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;

    logic             push;
    logic             pop;

    imm_extract #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_extract (
        .din     (din),
        .op      (op),
        .ext     (new_ext),
        .illegal (new_illegal)
    );

    // in_ready comes straight from the registered count so that upstream
    // never sees a combinational path from out_ready.
    assign in_ready  = (count != CNT_W'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid  && in_ready;
    assign pop       = out_valid && out_ready;

    // Outputs are forced to zero while empty so that stale entries left
    // behind by pops or a flush never show on the bus.
    assign ext         = out_valid ? mem_ext[rptr] : '0;
    assign out_illegal = out_valid ? mem_ill[rptr] : 1'b0;

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_ext[i] <= '0;
                mem_ill[i] <= 1'b0;
            end
        end else if (flush) begin
            // Any push or pop in the flush cycle is dropped.
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            if (push) begin
                mem_ext[wptr] <= new_ext;
                mem_ill[wptr] <= new_illegal;
                wptr          <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Drives an XLEN=32 and an XLEN=64 instance with identical stimulus and
// checks both against an arithmetic model of the immediate formats plus a
// queue model of the 2-entry buffer.
// ----------------------------------------------------------------------------
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic        cpu_clk;
    logic        cpu_rstn;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] din;
    logic [3:0]  op;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] ext32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] ext64;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    typedef struct {
        logic [63:0] e64;
        logic [31:0] e32;
        logic        ill;
    } exp_t;

    exp_t        model_q[$];
    exp_t        m_entry;
    logic [63:0] m_tmp;
    bit          m_push;
    bit          m_pop;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .cpu_clk     (cpu_clk),
        .cpu_rstn    (cpu_rstn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready32),
        .din         (din),
        .op          (op),
        .out_valid   (out_valid32),
        .out_ready   (out_ready),
        .ext         (ext32),
        .out_illegal (out_illegal32)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .cpu_clk     (cpu_clk),
        .cpu_rstn    (cpu_rstn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready64),
        .din         (din),
        .op          (op),
        .out_valid   (out_valid64),
        .out_ready   (out_ready),
        .ext         (ext64),
        .out_illegal (out_illegal64)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // Immediate value as a plain signed number, built from field weights.
    function automatic logic [63:0] model_imm(input logic [31:0] d, input logic [3:0] o, input int xlen);
        longint v;
        case (o)
            4'd0: v = 0;
            4'd1: v = longint'($signed(d)) >>> 20;
            4'd2: v = longint'((d >> 20) & 32'(xlen - 1));
            4'd3: v = (longint'($signed(d)) >>> 25) * 32 + longint'(d[11:7]);
            4'd4: v = (d[31] ? -64'sd4096 : 64'sd0) + longint'(d[7]) * 2048
                      + longint'(d[30:25]) * 32 + longint'(d[11:8]) * 2;
            4'd5: v = longint'($signed(d & 32'hFFFFF000));
            4'd6: v = (d[31] ? -64'sd1048576 : 64'sd0) + longint'(d[19:12]) * 4096
                      + longint'(d[20]) * 2048 + longint'(d[30:21]) * 2;
            4'd7: v = longint'((d >> 15) & 32'd31);
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [3:0] o,
                                 input logic r, input logic f);
        in_valid  = v;
        din       = d;
        op        = o;
        out_ready = r;
        flush     = f;
        @(posedge cpu_clk);
        #1;
    endtask

    // Buffer model: a queue of at most two expected entries.
    always @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn || flush) begin
            model_q.delete();
        end else begin
            m_push = in_valid && (model_q.size() < 2);
            m_pop  = out_ready && (model_q.size() > 0);
            if (m_pop) void'(model_q.pop_front());
            if (m_push) begin
                m_entry.e64 = model_imm(din, op, 64);
                m_tmp       = model_imm(din, op, 32);
                m_entry.e32 = m_tmp[31:0];
                m_entry.ill = (op > 4'd7);
                model_q.push_back(m_entry);
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge cpu_clk) begin
        if (cmp_en) begin
            checkOutput("in_ready32",  64'(in_ready32),  64'(model_q.size() < 2));
            checkOutput("in_ready64",  64'(in_ready64),  64'(model_q.size() < 2));
            checkOutput("out_valid32", 64'(out_valid32), 64'(model_q.size() > 0));
            checkOutput("out_valid64", 64'(out_valid64), 64'(model_q.size() > 0));
            if (model_q.size() > 0) begin
                checkOutput("ext32",   64'(ext32),         64'(model_q[0].e32));
                checkOutput("ext64",   ext64,              model_q[0].e64);
                checkOutput("ill32",   64'(out_illegal32), 64'(model_q[0].ill));
                checkOutput("ill64",   64'(out_illegal64), 64'(model_q[0].ill));
            end
        end
    end

    task automatic checkHead(input string name, input logic [31:0] e32, input logic [63:0] e64, input logic ill);
        checkOutput({name, " valid"}, 64'(out_valid64 & out_valid32), 64'd1);
        checkOutput({name, " ext32"}, 64'(ext32), 64'(e32));
        checkOutput({name, " ext64"}, ext64, e64);
        checkOutput({name, " ill"},   64'({out_illegal32, out_illegal64}), ill ? 64'd3 : 64'd0);
    endtask

    task automatic checkIdleOutputs(input string name);
        checkOutput({name, " out_valid"}, 64'({out_valid32, out_valid64}), 64'd0);
        checkOutput({name, " ext"},       ext64 | 64'(ext32), 64'd0);
        checkOutput({name, " ill"},       64'({out_illegal32, out_illegal64}), 64'd0);
        checkOutput({name, " in_ready"},  64'({in_ready32, in_ready64}), 64'd3);
    endtask

    logic [31:0] tbl_din [8];

    initial begin
        in_valid  = 1'b0;
        din       = '0;
        op        = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        cpu_rstn  = 1'b1;
        #1 cpu_rstn = 1'b0;
        #1 cmp_en = 1'b1;

        // Pin the model itself to hand-computed values.
        checkOutput("model B64",    model_imm(32'hFE000EE3, 4'd4, 64), 64'hFFFFFFFFFFFFFFFC);
        checkOutput("model U64",    model_imm(32'h80000037, 4'd5, 64), 64'hFFFFFFFF80000000);
        checkOutput("model MOVE32", model_imm(32'h03F09093, 4'd2, 32), 64'd31);
        checkOutput("model S",      model_imm(32'h00A12423, 4'd3, 64), 64'd8);
        checkOutput("model J",      model_imm(32'h0080006F, 4'd6, 64), 64'd8);

        @(posedge cpu_clk);
        @(posedge cpu_clk);
        #1;
        checkIdleOutputs("reset");
        #2 cpu_rstn = 1'b1;
        @(posedge cpu_clk);
        #1;
        $display("[TB] single-vector formats");

        applyStimulus(1'b1, 32'hFFF00093, 4'd1, 1'b1, 1'b0);
        checkHead("I", 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        applyStimulus(1'b1, 32'hFE000EE3, 4'd4, 1'b1, 1'b0);
        checkHead("B", 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        applyStimulus(1'b1, 32'h80000037, 4'd5, 1'b1, 1'b0);
        checkHead("U", 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        applyStimulus(1'b1, 32'h03F09093, 4'd2, 1'b1, 1'b0);
        checkHead("MOVE", 32'd31, 64'd63, 1'b0);
        applyStimulus(1'b1, 32'h340FD073, 4'd7, 1'b1, 1'b0);
        checkHead("Z", 32'h1F, 64'h1F, 1'b0);
        applyStimulus(1'b1, 32'hFFFFFFFF, 4'd9, 1'b1, 1'b0);
        checkHead("undef", 32'd0, 64'd0, 1'b1);
        applyStimulus(1'b1, 32'h00A12423, 4'd3, 1'b1, 1'b0);
        checkHead("S", 32'd8, 64'd8, 1'b0);
        applyStimulus(1'b1, 32'h0080006F, 4'd6, 1'b1, 1'b0);
        checkHead("J", 32'd8, 64'd8, 1'b0);
        applyStimulus(1'b1, 32'hFFFFFFFF, 4'd0, 1'b1, 1'b0);
        checkHead("R", 32'd0, 64'd0, 1'b0);
        applyStimulus(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
        checkOutput("drained valid", 64'(out_valid64), 64'd0);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'h00100093, 4'd1, 1'b0, 1'b0);
        checkOutput("bp in_ready after 1", 64'(in_ready64), 64'd1);
        applyStimulus(1'b1, 32'h00200093, 4'd1, 1'b0, 1'b0);
        checkOutput("bp in_ready after 2", 64'(in_ready64), 64'd0);
        applyStimulus(1'b1, 32'h00300093, 4'd1, 1'b0, 1'b0);
        checkHead("bp stalled head", 32'd1, 64'd1, 1'b0);
        applyStimulus(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
        checkHead("bp second", 32'd2, 64'd2, 1'b0);
        applyStimulus(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
        checkOutput("bp empty", 64'({out_valid32, out_valid64, in_ready32, in_ready64}), 64'b0011);

        $display("[TB] flush");
        applyStimulus(1'b1, 32'h00100093, 4'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00200093, 4'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00300093, 4'd1, 1'b0, 1'b1);
        checkOutput("flush full", 64'({out_valid32, out_valid64, in_ready32, in_ready64}), 64'b0011);
        applyStimulus(1'b1, 32'h00400093, 4'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00500093, 4'd1, 1'b1, 1'b1);
        checkOutput("flush push discarded", 64'(out_valid64), 64'd0);
        applyStimulus(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
        checkOutput("flush stays empty", 64'(out_valid32), 64'd0);

        $display("[TB] mixed sweep");
        tbl_din[0] = 32'h8A5F3C93;
        tbl_din[1] = 32'h7FF0F0B3;
        tbl_din[2] = 32'hC3A2E523;
        tbl_din[3] = 32'h00000013;
        tbl_din[4] = 32'hFFFFFFFF;
        tbl_din[5] = 32'h5555AAAB;
        tbl_din[6] = 32'hA0B1C2E3;
        tbl_din[7] = 32'h123456EF;
        for (int i = 0; i < 40; i++) begin
            applyStimulus((i % 5) != 4, tbl_din[i % 8], 4'(i % 16), (i % 3) != 2, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
        end

        $display("[TB] asynchronous reset mid-stream");
        applyStimulus(1'b1, 32'hFFF00093, 4'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hFFFFFFFF, 4'd12, 1'b0, 1'b0);
        checkHead("pre-reset head", 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        in_valid = 1'b0;
        #2 cpu_rstn = 1'b0;
        #1;
        checkIdleOutputs("async reset");
        @(posedge cpu_clk);
        #3 cpu_rstn = 1'b1;
        @(posedge cpu_clk);
        #1;
        applyStimulus(1'b1, 32'hFE000EE3, 4'd4, 1'b0, 1'b0);
        checkHead("after reset", 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        applyStimulus(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 4'd0, 1'b1, 1'b0);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. Accepts one instruction word plus an immediate-type code per handshake, extracts and extends the immediate to `XLEN` bits, and presents it through a 2-entry output skid buffer with valid/ready flow control and flush. It sits between instruction fetch/decode and the execute-stage operand mux. It supports RV32 and RV64 widths, zero-extended CSR immediates and illegal-type flagging.

## Interface
Parameters:
- `XLEN`, 32, datapath width; legal values 32 or 64.
- `SHW`, `$clog2(XLEN)`, shift-amount width (5 or 6); derived, not overridden.

Ports:
- `cpu_clk`  in  1  clock; all state updates on rising edge.
- `cpu_rstn`  in  1  reset; asynchronous, active-low.
- `flush`  in  1  synchronous pipeline flush.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  block can accept this cycle.
- `din`  in  32  instruction word.
- `op`  in  4  immediate type (codes in package).
- `out_valid`  out  1  `ext`/`out_illegal` valid.
- `out_ready`  in  1  downstream consumes this cycle.
- `ext`  out  XLEN  extended immediate.
- `out_illegal`  out  1  `op` was not a defined code.

## Operation
- Op codes: R=0, I=1, MOVE=2, S=3, B=4, U=5, J=6, Z=7; 8–15 undefined.
- Extraction, with s = `din[31]` replicated to XLEN:
  - R: 0.
  - I: s, `din[31:20]`.
  - MOVE: zero-extended `din[20+SHW-1:20]`.
  - S: s, `din[31:25]`, `din[11:7]`.
  - B: s, `din[7]`, `din[30:25]`, `din[11:8]`, 0.
  - U: `din[31:12]`, 12'b0, then sign-extended from bit 31 to XLEN.
  - J: s, `din[19:12]`, `din[20]`, `din[30:21]`, 0.
  - Z: zero-extended `din[19:15]`.
- Undefined op: `ext`=0, `out_illegal`=1. Undefined ops are still accepted and passed through in order.
- Push: `in_valid && in_ready`. Pop: `out_valid && out_ready`.
- Storage is a 2-entry FIFO of {ext, illegal} with occupancy `count` in 0..2.
- `in_ready` = (`count` != 2). It depends only on the registered count, with no combinational path from `out_ready`.
- `out_valid` = (`count` != 0). Head entry drives `ext`/`out_illegal`.
- Count update: push only +1; pop only −1; both unchanged.
- Push with pop at count 1: the new entry becomes head next cycle.
- Push at count 2 cannot occur because `in_ready` is low.
- `flush`: count→0 next edge. A push or pop in the same cycle is discarded, and `flush` has priority over both.
- Read/write pointers wrap modulo 2.

## Timing
- Latency: a push at edge N gives `out_valid` from edge N+1 when the FIFO was empty.
- Throughput is 1 per cycle while `out_ready` is held high.
- Downstream stall: two further pushes are absorbed, then `in_ready` drops the cycle after the second push.
- While `out_valid` is high and `out_ready` is low, `ext` and `out_illegal` hold stable.
- Reset (asynchronous assert, any time including mid-transfer): count=0, pointers=0, `out_valid`=0, `ext`=0, `out_illegal`=0, `in_ready`=1. Storage contents are cleared to 0.
- Reset deassertion takes effect on the first rising edge after release.

## Structure
- Package `imm_pkg`:
  - Op-code localparams `SEXT_R`..`SEXT_Z`.
  - Op width constant (4).
  - FIFO depth constant (2).
- Sub-module `imm_extract`:
  - Purely combinational, parametrised by `XLEN`.
  - `din`, `op` in; `ext`, `illegal` out.
  - Replaces the previous single-cycle extender.
- `imm_gen_pipe` holds only the FIFO, count, pointers and handshake logic.

## Test plan
- XLEN=32 I: `din`=0xFFF00093, op=1 → next cycle `out_valid`=1, `ext`=0xFFFFFFFF. B: `din`=0xFE000EE3, op=4 → 0xFFFFFFFC.
- XLEN=64 U: `din`=0x80000037, op=5 → 0xFFFFFFFF80000000. MOVE: `din`=0x03F09093, op=2 → 63.
- Z: `din`=0x340FD073, op=7 → 0x1F. Op=9 → `ext`=0, `out_illegal`=1.
- Backpressure: hold `out_ready`=0 and push 3 → `in_ready` low after 2 pushes. Release → outputs drain in push order, one per cycle, then `in_ready`=1.
- Flush with count=2 and simultaneous push → next cycle `out_valid`=0, `in_ready`=1, and the pushed word never appears.
- Assert `cpu_rstn`=0 asynchronously mid-stream → `out_valid`, `ext` and `out_illegal` go to 0 immediately, without waiting for a clock edge, and `in_ready`=1.
